// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/write-back.
// Optional MC_CTRL_OVF_CHECK_EN enables overflow suppression of write-back for add/addi.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       upover,
    output logic       pc_wr,
    output logic [1:0] pc_src,
    output logic       ir_wr,
    output logic       rf_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       dm_wr,
    output logic       alu_src_b,
    output logic       ext_op,
    output logic [1:0] alu_ctr,
    output logic       ovf_trap,
    output logic       illegal,
    output logic       retire,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch = 4'h0,
        StDcd   = 4'h1,
        StExe   = 4'h2,
        StMadr  = 4'h3,
        StMrd   = 4'h4,
        StMwr   = 4'h5,
        StWb    = 4'h6,
        StMwb   = 4'h7,
        StBr    = 4'h8,
        StJmp   = 4'h9,
        StIdle  = 4'hF
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu,
        ClsMem,
        ClsBr,
        ClsJmp,
        ClsIll
    } cls_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAddiu = 6'b001001;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAddu  = 6'b100001;
    localparam logic [5:0] FnSubu  = 6'b100011;
    localparam logic [5:0] FnSlt   = 6'b101010;
    localparam logic [5:0] FnAdd   = 6'b100000;

    localparam logic [1:0] AluAdd  = 2'b00;
    localparam logic [1:0] AluSub  = 2'b01;
    localparam logic [1:0] AluOr   = 2'b10;
    localparam logic [1:0] AluSlt  = 2'b11;

    localparam logic [1:0] PcSeq   = 2'b00;
    localparam logic [1:0] PcBr    = 2'b01;
    localparam logic [1:0] PcJmp   = 2'b10;

    state_e     state_q, state_d;
    logic       ovf_q, ovf_d;

    cls_e       dec_cls;
    logic       dec_rtype;
    logic [1:0] dec_alu;
    logic       dec_ext;
    logic       dec_chk;
    logic       dec_add_like;

    // Instruction decode; op/funct hold the IR contents from DCD onwards.
    always_comb begin
        dec_cls      = ClsIll;
        dec_rtype    = 1'b0;
        dec_alu      = AluAdd;
        dec_ext      = 1'b0;
        dec_add_like = 1'b0;
        case (op)
            OpRtype: begin
                dec_rtype = 1'b1;
                case (funct)
                    FnAddu: begin
                        dec_cls = ClsAlu;
                        dec_alu = AluAdd;
                    end
                    FnSubu: begin
                        dec_cls = ClsAlu;
                        dec_alu = AluSub;
                    end
                    FnSlt: begin
                        dec_cls = ClsAlu;
                        dec_alu = AluSlt;
                    end
                    FnAdd: begin
                        dec_cls      = ClsAlu;
                        dec_alu      = AluAdd;
                        dec_add_like = 1'b1;
                    end
                    default: dec_cls = ClsIll;
                endcase
            end
            OpOri: begin
                dec_cls = ClsAlu;
                dec_alu = AluOr;
                dec_ext = 1'b0;
            end
            OpAddi: begin
                dec_cls      = ClsAlu;
                dec_alu      = AluAdd;
                dec_ext      = 1'b1;
                dec_add_like = 1'b1;
            end
            OpAddiu: begin
                dec_cls = ClsAlu;
                dec_alu = AluAdd;
                dec_ext = 1'b1;
            end
            OpLw, OpSw: dec_cls = ClsMem;
            OpBeq:      dec_cls = ClsBr;
            OpJ:        dec_cls = ClsJmp;
            default:    dec_cls = ClsIll;
        endcase
    end

`ifdef MC_CTRL_OVF_CHECK_EN
    assign dec_chk = dec_add_like;
`else
    // Without the check, add/addi degrade to addu/addiu and ovf_q never sets.
    assign dec_chk = 1'b0 & dec_add_like;
`endif

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: state_d = StDcd;
            StDcd: begin
                ovf_d = 1'b0;
                case (dec_cls)
                    ClsAlu:  state_d = StExe;
                    ClsMem:  state_d = StMadr;
                    ClsBr:   state_d = StBr;
                    ClsJmp:  state_d = StJmp;
                    default: state_d = StFetch;
                endcase
            end
            StExe: begin
                state_d = StWb;
                ovf_d   = upover & dec_chk;
            end
            StMadr:  state_d = (op == OpLw) ? StMrd : StMwr;
            StMrd:   state_d = StMwb;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        pc_wr      = 1'b0;
        pc_src     = PcSeq;
        ir_wr      = 1'b0;
        rf_wr      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        dm_wr      = 1'b0;
        alu_src_b  = 1'b0;
        ext_op     = 1'b0;
        alu_ctr    = AluAdd;
        ovf_trap   = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (state_q)
            StFetch: begin
                ir_wr = 1'b1;
                pc_wr = 1'b1;
            end
            StDcd: begin
                illegal = (dec_cls == ClsIll);
                retire  = (dec_cls == ClsIll);
            end
            StExe: begin
                alu_ctr   = dec_alu;
                alu_src_b = ~dec_rtype;
                ext_op    = dec_ext;
            end
            StMadr: begin
                alu_ctr   = AluAdd;
                alu_src_b = 1'b1;
                ext_op    = 1'b1;
            end
            StMwr: begin
                dm_wr  = 1'b1;
                retire = 1'b1;
            end
            StWb: begin
                rf_wr    = ~ovf_q;
                reg_dst  = dec_rtype;
                ovf_trap = ovf_q;
                retire   = 1'b1;
            end
            StMwb: begin
                rf_wr      = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            StBr: begin
                alu_ctr = AluSub;
                pc_wr   = zero;
                pc_src  = PcBr;
                retire  = 1'b1;
            end
            StJmp: begin
                pc_wr  = 1'b1;
                pc_src = PcJmp;
                retire = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: a per-instruction reference model queues the expected
// per-cycle output vector, and a negedge monitor pops and compares every cycle.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       upover = 1'b0;
    logic       pc_wr, ir_wr, rf_wr, reg_dst, mem_to_reg, dm_wr, alu_src_b, ext_op;
    logic       ovf_trap, illegal, retire;
    logic [1:0] pc_src, alu_ctr;
    logic [3:0] state;

`ifdef MC_CTRL_OVF_CHECK_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] st;
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       ir_wr;
        logic       rf_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       dm_wr;
        logic       alu_src_b;
        logic       ext_op;
        logic [1:0] alu_ctr;
        logic       ovf_trap;
        logic       illegal;
        logic       retire;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   inst_no = 0;

    mc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .upover     (upover),
        .pc_wr      (pc_wr),
        .pc_src     (pc_src),
        .ir_wr      (ir_wr),
        .rf_wr      (rf_wr),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .dm_wr      (dm_wr),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .alu_ctr    (alu_ctr),
        .ovf_trap   (ovf_trap),
        .illegal    (illegal),
        .retire     (retire),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic rec_t got_rec();
        rec_t r;
        r = '{st: state, pc_wr: pc_wr, pc_src: pc_src, ir_wr: ir_wr, rf_wr: rf_wr,
              reg_dst: reg_dst, mem_to_reg: mem_to_reg, dm_wr: dm_wr, alu_src_b: alu_src_b,
              ext_op: ext_op, alu_ctr: alu_ctr, ovf_trap: ovf_trap, illegal: illegal,
              retire: retire};
        return r;
    endfunction

    // Instruction kinds: 0 R-alu, 1 I-alu, 2 lw, 3 sw, 4 beq, 5 j, 6 illegal.
    function automatic void classify(input logic [5:0] o, input logic [5:0] f, output int kind,
                                     output logic [1:0] alu, output logic ext,
                                     output logic chk);
        kind = 6; alu = 2'b00; ext = 1'b0; chk = 1'b0;
        if (o == 6'b000000) begin
            kind = 0;
            if (f == 6'b100001) alu = 2'b00;
            else if (f == 6'b100011) alu = 2'b01;
            else if (f == 6'b101010) alu = 2'b11;
            else if (f == 6'b100000) chk = OvfEn;
            else kind = 6;
        end else if (o == 6'b001101) begin kind = 1; alu = 2'b10; ext = 1'b0; end
        else if (o == 6'b001000) begin kind = 1; ext = 1'b1; chk = OvfEn; end
        else if (o == 6'b001001) begin kind = 1; ext = 1'b1; end
        else if (o == 6'b100011) kind = 2;
        else if (o == 6'b101011) kind = 3;
        else if (o == 6'b000100) kind = 4;
        else if (o == 6'b000010) kind = 5;
    endfunction

    // Builds the expected per-cycle trace of one instruction; zv/uv are the flag values per cycle.
    function automatic void model(input logic [5:0] o, input logic [5:0] f, input logic zv[10],
                                  input logic uv[10], output rec_t tr[10], output int n);
        int kind; logic [1:0] alu; logic ext, chk, ovf;
        classify(o, f, kind, alu, ext, chk);
        for (int i = 0; i < 10; i++) tr[i] = '0;
        tr[0].st = 4'h0; tr[0].ir_wr = 1'b1; tr[0].pc_wr = 1'b1;
        tr[1].st = 4'h1;
        case (kind)
            0, 1: begin
                ovf = chk & uv[2];
                tr[2].st = 4'h2; tr[2].alu_ctr = alu; tr[2].alu_src_b = (kind == 1);
                tr[2].ext_op = ext;
                tr[3].st = 4'h6; tr[3].rf_wr = ~ovf; tr[3].reg_dst = (kind == 0);
                tr[3].ovf_trap = ovf; tr[3].retire = 1'b1;
                n = 4;
            end
            2, 3: begin
                tr[2].st = 4'h3; tr[2].alu_src_b = 1'b1; tr[2].ext_op = 1'b1;
                if (kind == 2) begin
                    tr[3].st = 4'h4;
                    tr[4].st = 4'h7; tr[4].rf_wr = 1'b1; tr[4].mem_to_reg = 1'b1;
                    tr[4].retire = 1'b1;
                    n = 5;
                end else begin
                    tr[3].st = 4'h5; tr[3].dm_wr = 1'b1; tr[3].retire = 1'b1;
                    n = 4;
                end
            end
            4: begin
                tr[2].st = 4'h8; tr[2].alu_ctr = 2'b01; tr[2].pc_wr = zv[2];
                tr[2].pc_src = 2'b01; tr[2].retire = 1'b1;
                n = 3;
            end
            5: begin
                tr[2].st = 4'h9; tr[2].pc_wr = 1'b1; tr[2].pc_src = 2'b10; tr[2].retire = 1'b1;
                n = 3;
            end
            default: begin
                tr[1].illegal = 1'b1; tr[1].retire = 1'b1;
                n = 2;
            end
        endcase
    endfunction

    // Called #1 after the edge that enters FETCH; returns #1 after the edge of the next FETCH.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zsel,
                             input int usel);
        logic zv[10], uv[10];
        rec_t tr[10];
        int   n;
        for (int i = 0; i < 10; i++) begin
            zv[i] = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            uv[i] = (usel < 0) ? 1'($urandom_range(0, 1)) : 1'(usel);
        end
        model(o, f, zv, uv, tr, n);
        for (int i = 0; i < n; i++) exp_q.push_back(tr[i]);
        inst_no++;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i == 0) begin
                op = o;
                funct = f;
            end
            zero = zv[i];
            upover = uv[i];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_rst(input string name);
        rec_t g;
        g = got_rec();
        checks++;
        if (g !== rec_t'({4'hF, 15'h0})) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, g, rec_t'({4'hF, 15'h0}));
        end
    endtask

    always @(negedge clk) begin
        rec_t e, g;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_rec();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cycle inst %0d: got %h required %h (state %0h vs %0h)",
                         inst_no, g, e, g.st, e.st);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d records pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] tab_op[11];
        logic [5:0] tab_fn[11];
        logic [5:0] o, f;
        int k;
        tab_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0d, 6'h08, 6'h09, 6'h23, 6'h2b, 6'h04, 6'h02};
        tab_fn = '{6'h21, 6'h23, 6'h2a, 6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_rst("reset_hold");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_rst("idle_after_release");
        @(posedge clk);
        #1;

        run_instr(6'b000000, 6'b100011, -1, -1);   // subu
        run_instr(6'b100011, 6'h15, -1, -1);       // lw
        run_instr(6'b101011, 6'h2a, -1, -1);       // sw
        run_instr(6'b000100, 6'h00, 1, -1);        // beq taken
        run_instr(6'b000100, 6'h00, 0, -1);        // beq not taken
        run_instr(6'b001000, 6'h00, -1, 1);        // addi overflow
        run_instr(6'b001000, 6'h00, -1, 0);        // addi clean
        run_instr(6'b000000, 6'b100000, -1, 1);    // add overflow
        run_instr(6'b111111, 6'h00, -1, -1);       // illegal op
        run_instr(6'b000000, 6'b000111, -1, -1);   // illegal funct
        run_instr(6'b000010, 6'h00, -1, -1);       // j

        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 99);
            if (k < 80) begin
                k = $urandom_range(0, 10);
                o = tab_op[k];
                f = (o == 6'h00) ? tab_fn[k] : 6'($urandom());
            end else if (k < 90) begin
                o = 6'h00;
                f = 6'($urandom());
            end else begin
                o = 6'($urandom());
                f = 6'($urandom());
            end
            run_instr(o, f, -1, -1);
        end

        // Abort an addu in EXE: reset must force IDLE at once with nothing retired.
        exp_q.push_back('{st: 4'h0, pc_wr: 1'b1, pc_src: 2'b00, ir_wr: 1'b1, default: '0});
        exp_q.push_back('{st: 4'h1, default: '0});
        op = 6'h00;
        funct = 6'b100001;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_rst("abort_in_exe");
        @(negedge clk);
        check_rst("abort_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            k = $urandom_range(0, 10);
            run_instr(tab_op[k], tab_fn[k], -1, -1);
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending records required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle MIPS control unit: a Moore state machine that sequences fetch, decode, execute, memory and write-back for each instruction. It sits directly upstream of the 2-bit-opcode ALU and drives its `alu_ctr`. It consumes the ALU's `zero` (branch resolve) and `upover` (signed-add overflow) flags, and issues the write enables and mux selects for PC, IR, register file and data memory.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `op`  in  6  IR[31:26], stable after FETCH
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag (a == b)
- `upover`  in  1  ALU signed-add overflow
- `pc_wr`  out  1  PC write enable
- `pc_src`  out  2  00 = PC+4, 01 = branch target, 10 = jump target
- `ir_wr`  out  1  IR write enable
- `rf_wr`  out  1  register-file write enable
- `reg_dst`  out  1  1 = rd, 0 = rt
- `mem_to_reg`  out  1  1 = DM read data, 0 = ALUOut
- `dm_wr`  out  1  data-memory write enable
- `alu_src_b`  out  1  1 = extended immediate, 0 = register B
- `ext_op`  out  1  1 = sign extend, 0 = zero extend
- `alu_ctr`  out  2  00 add, 01 sub, 10 or, 11 slt
- `ovf_trap`  out  1  one-cycle pulse: write-back suppressed by overflow
- `illegal`  out  1  one-cycle pulse: unknown opcode or funct
- `retire`  out  1  one-cycle pulse in the final state of each instruction
- `state`  out  4  current state (debug)

## Operation
- State encodings:
  - IDLE = 0xF
  - FETCH = 0
  - DCD = 1
  - EXE = 2
  - MADR = 3
  - MRD = 4
  - MWR = 5
  - WB = 6
  - MWB = 7
  - BR = 8
  - JMP = 9
- Decode:
  - R-type (op 000000) funct: 100001 addu → 00; 100011 subu → 01; 101010 slt → 11; 100000 add → 00 with overflow check.
  - I-type op: 001101 ori → 10, zero-ext; 001000 addi → 00, sign-ext, checked; 001001 addiu → 00, sign-ext; 100011 lw; 101011 sw; 000100 beq; 000010 j.
- Transitions:
  - IDLE → FETCH → DCD.
  - DCD → EXE for R-type, ori, addi, addiu; → MADR for lw, sw; → BR for beq; → JMP for j; → FETCH for illegal.
  - EXE → WB; MADR → MRD (lw) or MWR (sw); MRD → MWB.
  - WB, MWB, MWR, BR, JMP → FETCH.
- Outputs per state (any output not listed is 0):
  - IDLE: all outputs 0.
  - FETCH: `ir_wr` = 1, `pc_wr` = 1, `pc_src` = 00.
  - DCD: `illegal` = `retire` = 1 if undecodable.
  - EXE: `alu_ctr` per decode; `alu_src_b` = 1 for I-type; `ext_op` per decode.
  - MADR: `alu_ctr` = 00, `alu_src_b` = 1, `ext_op` = 1.
  - MWR: `dm_wr` = 1, `retire` = 1.
  - WB: `rf_wr` = !suppress, `reg_dst` = R-type, `ovf_trap` = suppress, `retire` = 1.
  - MWB: `rf_wr` = 1, `mem_to_reg` = 1, `reg_dst` = 0, `retire` = 1.
  - BR: `alu_ctr` = 01, `alu_src_b` = 0, `pc_wr` = `zero`, `pc_src` = 01, `retire` = 1.
  - JMP: `pc_wr` = 1, `pc_src` = 10, `retire` = 1.
- Overflow register `ovf_q`:
  - Cleared in DCD.
  - Loaded at the end of EXE with `upover` & checked (add or addi).
  - suppress = `ovf_q`.
- `upover` is sampled only in EXE. `zero` is used only in BR.

## Timing
- Reset:
  - Asynchronous assertion forces state = IDLE and `ovf_q` = 0; all outputs go to 0 immediately.
  - The first rising edge after release enters FETCH.
- Reset mid-instruction aborts it: no `retire`, no further writes.
- Outputs are combinational from the state register, `op`, `funct`, `ovf_q` and, in BR only, `zero`. There is no output register.
- CPI:
  - R-type, ori, addi, addiu, sw: 4.
  - lw: 5.
  - beq, j: 3.
  - illegal: 2.
- `retire` asserts exactly once per instruction, in its final cycle.
- BR: the branch is taken iff `zero` = 1 in the BR cycle. Untaken branches leave the PC at PC+4 from FETCH.
- Unknown funct under op 000000 is treated as illegal.

## Configuration
- `MC_CTRL_OVF_CHECK_EN`
  - Defined: add and addi use `ovf_q`; on overflow `rf_wr` = 0 in WB and `ovf_trap` pulses.
  - Undefined: add behaves exactly as addu and addi as addiu. `ovf_q` is held at 0 and `ovf_trap` is constant 0.

## Test plan
- Reset held 3 cycles, released: state = 0xF with all outputs 0 during reset → FETCH next edge with `ir_wr` = `pc_wr` = 1; reassert rst during EXE → immediate IDLE, no `retire`.
- op = 000000, funct = 100011 (subu): states 0,1,2,6; `alu_ctr` = 01 in EXE; `rf_wr` = 1 and `reg_dst` = 1 in WB; `retire` once; 4 cycles.
- lw (100011) then sw (101011): lw runs 0,1,3,4,7 with `mem_to_reg` = 1 in MWB; sw runs 0,1,3,5 with `dm_wr` = 1 for exactly one cycle.
- beq with `zero` = 1 → `pc_wr` = 1, `pc_src` = 01 in BR; with `zero` = 0 → `pc_wr` = 0; both 3 cycles.
- addi with `upover` = 1 in EXE, macro defined → WB has `rf_wr` = 0 and `ovf_trap` = 1. Macro undefined → `rf_wr` = 1, `ovf_trap` = 0. Next addi with `upover` = 0 → `rf_wr` = 1 (`ovf_q` cleared in DCD).
- op = 111111: FETCH → DCD with `illegal` = `retire` = 1 → FETCH; no write enables asserted.
